// File: rtl/fpu_result_buffer.sv
// In-order result FIFO between the FP add/sub stage and register-file writeback.
// Tracks sticky overflow / NaN-produced flags, which are updated as results commit.
module fpu_result_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_data,
  input  logic                     in_ovf,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
  input  logic                     flush,
  input  logic                     flag_clr,
  output logic                     flag_ovf,
  output logic                     flag_nan,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = 32 + TAG_W + 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // Entry layout: {data, tag, ovf}
  logic [EW-1:0]  mem_q [DEPTH];

  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           flag_ovf_q, flag_ovf_d;
  logic           flag_nan_q, flag_nan_d;

  logic           push;
  logic           pop;
  logic           mem_we;
  logic [EW-1:0]  head;
  logic           head_nan;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[EW-1 -: 32];
  assign out_tag   = head[TAG_W:1];
  assign out_ovf   = head[0];
  assign head_nan  = (out_data[30:23] == 8'hFF) && (out_data[22:0] != '0);

  assign count     = count_q;
  assign flag_ovf  = flag_ovf_q;
  assign flag_nan  = flag_nan_q;

  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    flag_ovf_d = flag_ovf_q;
    flag_nan_d = flag_nan_q;
    mem_we     = 1'b0;

    if (flag_clr) begin
      flag_ovf_d = 1'b0;
      flag_nan_d = 1'b0;
    end

    if (flush) begin
      // Flush drops any same-cycle push/pop, so the head never commits its flags.
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      mem_we = push;
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        if (out_ovf)  flag_ovf_d = 1'b1;
        if (head_nan) flag_nan_d = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + (AW + 1)'(1);
        2'b01:   count_d = count_q - (AW + 1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      flag_ovf_q <= 1'b0;
      flag_nan_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      flag_ovf_q <= flag_ovf_d;
      flag_nan_q <= flag_nan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem_q[wr_ptr_q] <= {in_data, in_tag, in_ovf};
  end

endmodule
